digit_scan: RTL and testbench
=============================

# digit_scan

Time-multiplexed scan controller for an 8-digit seven-segment display. It holds eight 4-bit digit values in a shadow bank and an active bank. It steps a 3-bit digit select at a programmable rate, and that select drives the 3-to-8 decoder inputs that generate the digit anode enables. The selected digit's nibble and a blank flag go to the segment encoder. Shadow-to-active transfer happens only on a frame boundary, so the display never tears.

## Interface
Parameters:
- PRESCALE, 50000, clock cycles per digit slot; legal range 1..2^20.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write wr_data into shadow[wr_addr] this cycle
- wr_addr  in  3  shadow digit index
- wr_data  in  4  hex value
- commit  in  1  single-cycle request to copy shadow to active at next frame boundary
- en_mask  in  8  per-digit enable; bit n enables digit n
- sel  out  3  current digit index; sel[2:0] connect to decoder i2,i1,i0
- digit  out  4  active[sel]
- blank  out  1  ~en_mask[sel]; the segment encoder forces segments off when set
- frame_start  out  1  one-cycle pulse in the first cycle of each new frame
- commit_done  out  1  one-cycle pulse in the first cycle a committed bank is displayed

## Operation
- Prescaler:
  - pcnt counts 0..PRESCALE-1, then wraps to 0.
  - tick = (pcnt == PRESCALE-1).
  - PRESCALE=1 gives tick every cycle.
- Scan: on tick, sel advances to the next index (see Configuration). Otherwise sel holds.
- Wrap event: a tick whose next sel is not greater than the current sel.
- Shadow bank:
  - Written whenever wr_en=1, independent of scan state.
  - Never read by the display path.
- Commit:
  - commit=1 sets pending. Repeated commits while pending are absorbed into one.
  - On a wrap event with pending=1, or with commit=1 in the same cycle:
    - active <= shadow; pending <= 0.
    - commit_done pulses in the following cycle.
- Same-cycle write and copy: the copy takes the pre-write shadow contents. The write lands in shadow only.
- digit and blank are combinational from active, sel and en_mask. sel is registered.
- frame_start is registered and high for the cycle after each wrap event.
- en_mask may change at any time:
  - blank follows immediately.
  - In skip mode the new mask applies from the next tick.
- Reset values, applied immediately and asynchronously:
  - pcnt=0, sel=0, pending=0, frame_start=0, commit_done=0.
  - shadow and active all zero, so digit=0.
  - blank = ~en_mask[0].
- A reset in mid-frame or with a commit pending discards the pending commit. Scan restarts at digit 0.

## Timing
- Digit dwell = PRESCALE cycles. Frame = 8*PRESCALE cycles in non-skip mode.
- Commit-to-visible latency: up to one frame plus 1 cycle. commit_done is coincident with the first cycle of the new active data.
- The write-to-shadow path has no output latency; shadow is not visible until commit.
- sel changes exactly one cycle after a tick.

## Configuration
- DIGIT_SCAN_SKIP_EN undefined:
  - sel steps 0,1,...,7,0 unconditionally.
  - Disabled digits are shown blanked for their full slot.
  - Wrap occurs on tick at sel=7.
- DIGIT_SCAN_SKIP_EN defined:
  - On tick, sel moves to the lowest enabled index above sel. If none exists, it moves to the lowest enabled index overall; that move is a wrap.
  - A single enabled digit wraps on every tick.
  - en_mask=0: sel forced to 0, every tick is a wrap, blank=1.

## Test plan
- Reset and defaults, PRESCALE=4, en_mask=8'hFF:
  - Assert rst mid-count -> sel=0, digit=0, blank=0, no pulses.
  - After release, sel increments every 4 cycles and reaches 7 at cycle 28.
- Shadow isolation, PRESCALE=2:
  - Write shadow[3]=4'hA without commit -> digit at sel=3 stays 0 across two frames.
- Commit alignment:
  - Write all digits 1..8, pulse commit at sel=2.
  - Required: digit unchanged until wrap; then commit_done and frame_start pulse together and digit=1 at sel=0.
- Same-cycle collision:
  - wr_en to shadow[0]=4'hF in the same cycle as a wrap with pending.
  - Required: active[0] gets the old value; 4'hF appears only after a second commit.
- Blanking, en_mask=8'b0000_0101, non-skip:
  - Required: blank=0 at sel 0 and 2, blank=1 elsewhere; frame length 8*PRESCALE.
- Skip mode, DIGIT_SCAN_SKIP_EN defined, same mask:
  - Required: sel sequence 0,2,0,2; frame_start pulses on every 2->0.
  - With en_mask=0: sel=0 and blank=1 constantly.

Source files
------------

// File: rtl/digit_scan.sv
// ============================================================================
// Module      : digit_scan
// Description : 8-digit seven-segment scan controller with a shadow bank and
//               an active bank swapped at frame boundaries. Define
//               DIGIT_SCAN_SKIP_EN to step only over enabled digits.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module digit_scan #(
    parameter int PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       commit,
    input  logic [7:0] en_mask,
    output logic [2:0] sel,
    output logic [3:0] digit,
    output logic       blank,
    output logic       frame_start,
    output logic       commit_done
);

    localparam int                    c_PCNT_W    = $clog2(PRESCALE + 1);
    localparam logic [c_PCNT_W-1:0]   c_PCNT_LAST = c_PCNT_W'(PRESCALE - 1);

    logic [c_PCNT_W-1:0] r_pcnt;
    logic [2:0]          r_sel;
    logic [31:0]         r_shadow;
    logic [31:0]         r_active;
    logic                r_pending;
    logic                r_frame_start;
    logic                r_commit_done;

    logic                w_tick;
    logic [2:0]          w_sel_nxt;
    logic                w_wrap;
    logic                w_copy;

    assign w_tick = (r_pcnt == c_PCNT_LAST);

    always_comb begin
        w_sel_nxt = 3'd0;
`ifdef DIGIT_SCAN_SKIP_EN
        // Descending scans so the lowest qualifying index is the last written;
        // the "above sel" pass overrides the wrap target only when one exists.
        for (int i = 7; i >= 0; i--) begin
            if (en_mask[i]) w_sel_nxt = 3'(i);
        end
        for (int i = 7; i >= 0; i--) begin
            if (en_mask[i] && (3'(i) > r_sel)) w_sel_nxt = 3'(i);
        end
`else
        w_sel_nxt = r_sel + 3'd1;
`endif
    end

    assign w_wrap = w_tick && (w_sel_nxt <= r_sel);
    assign w_copy = w_wrap && (r_pending || commit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt        <= '0;
            r_sel         <= 3'd0;
            r_shadow      <= 32'd0;
            r_active      <= 32'd0;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + c_PCNT_W'(1);
            if (w_tick) r_sel <= w_sel_nxt;
            if (wr_en) r_shadow[{wr_addr, 2'b00} +: 4] <= wr_data;
            // Copy samples pre-write shadow; a colliding write lands in shadow only.
            if (w_copy) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end else if (commit) begin
                r_pending <= 1'b1;
            end
            r_frame_start <= w_wrap;
            r_commit_done <= w_copy;
        end
    end

    assign sel         = r_sel;
    assign digit       = r_active[{r_sel, 2'b00} +: 4];
    assign blank       = ~en_mask[r_sel];
    assign frame_start = r_frame_start;
    assign commit_done = r_commit_done;

endmodule

`default_nettype wire

// File: tb/tb_digit_scan.sv
// ============================================================================
// Module      : tb_digit_scan
// Description : Directed vector bench for digit_scan at PRESCALE=4.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_digit_scan;

    localparam int PRESCALE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_data = 4'd0;
    logic       commit = 1'b0;
    logic [7:0] en_mask = 8'hFF;
    logic [2:0] sel;
    logic [3:0] digit;
    logic       blank;
    logic       frame_start;
    logic       commit_done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         adv;
        logic       we;
        logic [2:0] wa;
        logic [3:0] wd;
        logic       cm;
        logic [7:0] mask;
        logic [2:0] e_sel;
        logic [3:0] e_digit;
        logic       e_blank;
        logic       e_fs;
        logic       e_cd;
    } vec_t;

    vec_t vq[$];

    digit_scan #(.PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .en_mask(en_mask), .sel(sel),
        .digit(digit), .blank(blank), .frame_start(frame_start),
        .commit_done(commit_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input int adv, input logic we, input logic [2:0] wa,
                       input logic [3:0] wd, input logic cm, input logic [7:0] mask,
                       input logic [2:0] es, input logic [3:0] ed,
                       input logic eb, input logic efs, input logic ecd);
        vec_t v;
        v.adv = adv; v.we = we; v.wa = wa; v.wd = wd; v.cm = cm; v.mask = mask;
        v.e_sel = es; v.e_digit = ed; v.e_blank = eb; v.e_fs = efs; v.e_cd = ecd;
        vq.push_back(v);
    endtask

    initial begin
        // Comment on each line gives cycle count since reset release afterwards.
        add(0,  0, 0, 0, 0, 8'hFF, 0, 4'h0, 0, 0, 0);   // t0
        add(1,  1, 3, 4'hA, 0, 8'hFF, 0, 4'h0, 0, 0, 0); // t1
        add(11, 0, 0, 0, 0, 8'hFF, 3, 4'h0, 0, 0, 0);   // t12
        add(16, 0, 0, 0, 0, 8'hFF, 7, 4'h0, 0, 0, 0);   // t28
        add(4,  0, 0, 0, 0, 8'hFF, 0, 4'h0, 0, 1, 0);   // t32
        add(12, 0, 0, 0, 0, 8'hFF, 3, 4'h0, 0, 0, 0);   // t44
        add(32, 0, 0, 0, 0, 8'hFF, 3, 4'h0, 0, 0, 0);   // t76
        for (int a = 0; a < 8; a++)
            add(1, 1, 3'(a), 4'(a + 1), 0, 8'hFF, 3'(((77 + a) / 4) % 8), 4'h0, 0, 0, 0);
        add(20, 0, 0, 0, 0, 8'hFF, 2, 4'h0, 0, 0, 0);   // t104
        add(1,  0, 0, 0, 1, 8'hFF, 2, 4'h0, 0, 0, 0);   // t105 commit
        add(22, 0, 0, 0, 0, 8'hFF, 7, 4'h0, 0, 0, 0);   // t127
        add(1,  0, 0, 0, 0, 8'hFF, 0, 4'h1, 0, 1, 1);   // t128
        add(1,  0, 0, 0, 0, 8'hFF, 0, 4'h1, 0, 0, 0);   // t129
        add(3,  0, 0, 0, 0, 8'hFF, 1, 4'h2, 0, 0, 0);   // t132
        add(8,  0, 0, 0, 1, 8'hFF, 3, 4'h4, 0, 0, 0);   // t140 commit
        add(19, 0, 0, 0, 0, 8'hFF, 7, 4'h8, 0, 0, 0);   // t159
        add(1,  1, 0, 4'hF, 0, 8'hFF, 0, 4'h1, 0, 1, 1); // t160 collision
        add(31, 0, 0, 0, 1, 8'hFF, 7, 4'h8, 0, 0, 0);   // t191
        add(1,  0, 0, 0, 0, 8'hFF, 0, 4'hF, 0, 1, 1);   // t192
        add(8,  1, 1, 4'hC, 0, 8'hFF, 2, 4'h3, 0, 0, 0); // t200
        add(23, 0, 0, 0, 0, 8'hFF, 7, 4'h8, 0, 0, 0);   // t223
        add(1,  0, 0, 0, 1, 8'hFF, 0, 4'hF, 0, 1, 1);   // t224 commit on wrap
        add(4,  0, 0, 0, 0, 8'hFF, 1, 4'hC, 0, 0, 0);   // t228
        add(0,  0, 0, 0, 0, 8'h05, 1, 4'hC, 1, 0, 0);   // t228 mask change
        add(4,  0, 0, 0, 0, 8'h05, 2, 4'h3, 0, 0, 0);   // t232
`ifdef DIGIT_SCAN_SKIP_EN
        add(4,  0, 0, 0, 0, 8'h05, 0, 4'hF, 0, 1, 0);   // t236
        add(4,  0, 0, 0, 0, 8'h05, 2, 4'h3, 0, 0, 0);   // t240
        add(4,  0, 0, 0, 0, 8'h05, 0, 4'hF, 0, 1, 0);   // t244
        add(4,  0, 0, 0, 0, 8'h05, 2, 4'h3, 0, 0, 0);   // t248
        add(0,  0, 0, 0, 0, 8'h00, 2, 4'h3, 1, 0, 0);   // t248 mask off
        add(4,  0, 0, 0, 0, 8'h00, 0, 4'hF, 1, 1, 0);   // t252
        add(1,  0, 0, 0, 0, 8'h00, 0, 4'hF, 1, 0, 0);   // t253
        add(3,  0, 0, 0, 0, 8'h00, 0, 4'hF, 1, 1, 0);   // t256
`else
        add(4,  0, 0, 0, 0, 8'h05, 3, 4'h4, 1, 0, 0);   // t236
        add(20, 0, 0, 0, 0, 8'h05, 0, 4'hF, 0, 1, 0);   // t256
        add(4,  0, 0, 0, 0, 8'h05, 1, 4'hC, 1, 0, 0);   // t260
        add(28, 0, 0, 0, 0, 8'h05, 0, 4'hF, 0, 1, 0);   // t288
        add(8,  0, 0, 0, 0, 8'h05, 2, 4'h3, 0, 0, 0);   // t296
`endif

        // Mid-frame reset with a commit pending.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_sel", -1, 8'(sel), 8'd1);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'h9; commit = 1'b1;
        @(posedge clk);
        #1 wr_en = 1'b0; commit = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_sel",   -1, 8'(sel),         8'd0);
        chk("rst_digit", -1, 8'(digit),       8'd0);
        chk("rst_blank", -1, 8'(blank),       8'd0);
        chk("rst_fs",    -1, 8'(frame_start), 8'd0);
        chk("rst_cd",    -1, 8'(commit_done), 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vq[i]) begin
            wr_en = vq[i].we; wr_addr = vq[i].wa; wr_data = vq[i].wd;
            commit = vq[i].cm; en_mask = vq[i].mask;
            #1;
            for (int k = 0; k < vq[i].adv; k++) begin
                @(posedge clk);
                #1;
                if (k == 0) begin
                    wr_en = 1'b0;
                    commit = 1'b0;
                end
            end
            chk("sel",         i, 8'(sel),         8'(vq[i].e_sel));
            chk("digit",       i, 8'(digit),       8'(vq[i].e_digit));
            chk("blank",       i, 8'(blank),       8'(vq[i].e_blank));
            chk("frame_start", i, 8'(frame_start), 8'(vq[i].e_fs));
            chk("commit_done", i, 8'(commit_done), 8'(vq[i].e_cd));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
